// File: rtl/gen_reduce.sv
// Sink for a generator stream: launches one run with forwarded arguments, drains every beat,
// and reduces the stream to count / sum / min / max behind a ready/valid result handshake.
module gen_reduce #(
  parameter int WIDTH          = 32,
  parameter int COUNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                                _clock,
  input  logic                                _reset,
  input  logic                                _start,
  input  logic signed [WIDTH-1:0]             base,
  input  logic signed [WIDTH-1:0]             limit,
  input  logic signed [WIDTH-1:0]             step,
  input  logic                                throttle,
  input  logic                                _ready,
  output logic                                _valid,
  output logic                                _busy,
  output logic [COUNT_WIDTH-1:0]              _count,
  output logic signed [WIDTH+COUNT_WIDTH-1:0] _sum,
  output logic signed [WIDTH-1:0]             _min,
  output logic signed [WIDTH-1:0]             _max,
  output logic                                _timeout,
  output logic signed [WIDTH-1:0]             gen_base,
  output logic signed [WIDTH-1:0]             gen_limit,
  output logic signed [WIDTH-1:0]             gen_step,
  output logic                                gen__start,
  output logic                                gen__ready,
  input  logic signed [WIDTH-1:0]             gen_out0,
  input  logic                                gen__valid,
  input  logic                                gen__done
);

  typedef enum logic [1:0] {IDLE, START, COLLECT, RESULT} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] timer;
  logic        accept;
  logic        end_stream;
  logic        timer_hit;

  // Handshake outputs are decoded straight from state so an async reset drops them at once.
  assign _valid     = (state == RESULT);
  assign _busy      = (state != IDLE);
  assign gen__start = (state == START);
  assign gen__ready = (state == COLLECT) && !throttle;

  assign accept     = gen__ready && gen__valid;
  assign end_stream = (state == COLLECT) && gen__done && !gen__valid;
  assign timer_hit  = (TIMEOUT_CYCLES > 0) && (state == COLLECT) && !accept && !end_stream &&
                      (timer == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (_start) state_next = START;
      START:   state_next = COLLECT;
      COLLECT: if (end_stream || timer_hit) state_next = RESULT;
      RESULT:  if (_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      gen_base  <= '0;
      gen_limit <= '0;
      gen_step  <= '0;
      _count    <= '0;
      _sum      <= '0;
      _min      <= '0;
      _max      <= '0;
      _timeout  <= 1'b0;
      timer     <= '0;
    end else if (state == IDLE && _start) begin
      gen_base  <= base;
      gen_limit <= limit;
      gen_step  <= step;
      _count    <= '0;
      _sum      <= '0;
      _min      <= '0;
      _max      <= '0;
      _timeout  <= 1'b0;
      timer     <= '0;
    end else if (state == COLLECT) begin
      if (accept) begin
        if (_count != '1) _count <= _count + 1'b1;
        _sum  <= _sum + {{COUNT_WIDTH{gen_out0[WIDTH-1]}}, gen_out0};
        // An empty accumulator (count 0) means this is the first beat: load both extremes.
        if (_count == '0 || gen_out0 < _min) _min <= gen_out0;
        if (_count == '0 || gen_out0 > _max) _max <= gen_out0;
        timer <= '0;
      end else if (TIMEOUT_CYCLES > 0 && !end_stream) begin
        timer <= timer + 32'd1;
        if (timer_hit) _timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gen_reduce.sv
// Bench for gen_reduce: a behavioural range generator feeds the DUT and a queue-based
// reference computes the expected summary of each run.
module tb_gen_reduce;
  localparam int W  = 32;
  localparam int CW = 16;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, throttle = 1'b0, ready = 1'b0;
  logic signed [W-1:0] base = '0, limit = '0, step = '0;

  logic                       valid, busy, timeout, gen_start, gen_ready;
  logic [CW-1:0]              count;
  logic signed [W+CW-1:0]     sum;
  logic signed [W-1:0]        min_v, max_v, gen_base, gen_limit, gen_step;
  logic signed [W-1:0]        gen_out0;
  logic                       gen_valid, gen_done;

  int errors = 0;
  int checks = 0;

  gen_reduce #(.WIDTH(W), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    ._clock(clk), ._reset(rst), ._start(start),
    .base(base), .limit(limit), .step(step),
    .throttle(throttle), ._ready(ready),
    ._valid(valid), ._busy(busy), ._count(count), ._sum(sum),
    ._min(min_v), ._max(max_v), ._timeout(timeout),
    .gen_base(gen_base), .gen_limit(gen_limit), .gen_step(gen_step),
    .gen__start(gen_start), .gen__ready(gen_ready),
    .gen_out0(gen_out0), .gen__valid(gen_valid), .gen__done(gen_done)
  );

  always #5 clk = ~clk;

  // Behavioural range generator: yields base, base+step, ... while below limit.
  int g_idx, g_n;
  bit g_silent = 1'b0;

  function automatic int range_len(input int b, input int l, input int s);
    if (s <= 0 || b >= l) return 0;
    return (l - b + s - 1) / s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      g_idx <= 0;
      g_n   <= 0;
    end else if (gen_start) begin
      g_idx <= 0;
      g_n   <= range_len(gen_base, gen_limit, gen_step);
    end else if (gen_ready && gen_valid) begin
      g_idx <= g_idx + 1;
    end
  end

  assign gen_valid = !g_silent && (g_idx < g_n);
  assign gen_done  = !g_silent && (g_idx >= g_n);
  assign gen_out0  = gen_base + gen_step * g_idx;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference summary computed from the range definition itself.
  task automatic ref_model(input int b, input int l, input int s,
                           output longint ec, output longint es, output longint emn, output longint emx);
    longint q[$];
    for (longint v = b; v < l; v += s) q.push_back(v);
    ec = q.size(); es = 0; emn = 0; emx = 0;
    foreach (q[i]) begin
      es += q[i];
      if (i == 0 || q[i] < emn) emn = q[i];
      if (i == 0 || q[i] > emx) emx = q[i];
    end
  endtask

  // tmode: 0 throttle low, 1 toggle every cycle, 2 random (at most 3 high in a row)
  task automatic run_one(input int b, input int l, input int s, input int tmode,
                         input int hold, input bit poke, input bit expect_to);
    longint ec, es, emn, emx;
    int collect_cycles = 0;
    int t_run = 0;
    bit viol = 1'b0;
    bit got = 1'b0;
    if (expect_to) begin ec = 0; es = 0; emn = 0; emx = 0; end
    else ref_model(b, l, s, ec, es, emn, emx);

    @(negedge clk);
    base = b; limit = l; step = s; start = 1'b1; ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("gen_start_rise", 64'(gen_start), 64'(1'b1));
    check("gen_base_fwd", 64'(gen_base), 64'(b));
    @(negedge clk);
    check("gen_start_width", 64'(gen_start), 64'(1'b0));

    for (int cyc = 0; cyc < 400 && !got; cyc++) begin
      if (valid) got = 1'b1;
      else begin
        collect_cycles++;
        case (tmode)
          1: throttle = cyc[0];
          2: begin
            throttle = (t_run >= 3) ? 1'b0 : 1'($urandom_range(0, 1));
            t_run = throttle ? t_run + 1 : 0;
          end
          default: throttle = 1'b0;
        endcase
        #1;
        if (throttle && gen_ready) viol = 1'b1;
        @(negedge clk);
      end
    end
    throttle = 1'b0;
    check("result_within_budget", 64'(got), 64'(1'b1));
    check("no_ready_while_throttled", 64'(viol), 64'(1'b0));
    if (expect_to) check("timeout_latency", 64'(collect_cycles), 64'(TO));

    for (int i = 0; i < hold; i++) begin
      start = (poke && i == 1);
      @(negedge clk);
    end
    start = 1'b0;
    check("valid", 64'(valid), 64'(1'b1));
    check("count", 64'(count), 64'(ec));
    check("sum", 64'(sum), 64'(es));
    check("min", 64'(min_v), 64'(emn));
    check("max", 64'(max_v), 64'(emx));
    check("timeout_flag", 64'(timeout), 64'(expect_to));
    check("gen_ready_in_result", 64'(gen_ready), 64'(1'b0));

    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("valid_after_handshake", 64'(valid), 64'(1'b0));
    check("idle_after_handshake", 64'(busy), 64'(1'b0));
    $display("run base=%0d limit=%0d step=%0d throttle_mode=%0d hold=%0d -> count=%0d sum=%0d min=%0d max=%0d timeout=%0d",
             b, l, s, tmode, hold, count, sum, min_v, max_v, timeout);
  endtask

  initial begin
    #2;
    check("rst_valid", 64'(valid), 64'(1'b0));
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_gen_start", 64'(gen_start), 64'(1'b0));
    check("rst_gen_ready", 64'(gen_ready), 64'(1'b0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_min_max", 64'(min_v) | 64'(max_v), 64'(0));
    check("rst_timeout", 64'(timeout), 64'(1'b0));
    @(negedge clk);
    rst = 1'b0;

    run_one(1, 11, 3, 0, 0, 1'b0, 1'b0);
    run_one(0, 10, 2, 1, 0, 1'b0, 1'b0);
    run_one(0, 10, 2, 0, 0, 1'b0, 1'b0);
    run_one(5, 5, 1, 0, 0, 1'b0, 1'b0);
    g_silent = 1'b1;
    run_one(0, 10, 1, 0, 0, 1'b0, 1'b1);
    g_silent = 1'b0;
    run_one(1, 11, 3, 0, 5, 1'b1, 1'b0);

    // Async reset in the middle of collection, after two beats were accepted.
    @(negedge clk);
    base = 0; limit = 10; step = 2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_collect_count", 64'(count), 64'(2));
    check("mid_collect_ready", 64'(gen_ready), 64'(1'b1));
    rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'(1'b0));
    check("async_rst_gen_ready", 64'(gen_ready), 64'(1'b0));
    check("async_rst_valid", 64'(valid), 64'(1'b0));
    check("async_rst_count", 64'(count), 64'(0));
    #1;
    rst = 1'b0;
    run_one(0, 10, 2, 1, 0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int b, s, l;
      b = int'($urandom_range(0, 200)) - 100;
      s = int'($urandom_range(1, 7));
      l = b + int'($urandom_range(0, 60));
      run_one(b, l, s, 2, int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/gen_reduce.md
Name: gen_reduce

Overview:
- Downstream consumer for a generated generator module (for example hrange). It follows the generator's _start / _ready / _valid / _done protocol.
- It launches one generator run with forwarded arguments, drains every _out0 beat, and reduces the stream to count, sum, min and max.
- It presents the reduced result through its own ready/valid handshake.
- It is the sink used wherever a generator stream must collapse to a scalar summary, such as self-checking harnesses and reduction wrappers.

Parameters:
- WIDTH, 32: width of the signed generator arguments and of gen_out0.
- COUNT_WIDTH, 16: width of the beat counter. The sum width is WIDTH+COUNT_WIDTH.
- TIMEOUT_CYCLES, 0: consecutive idle COLLECT cycles before abort. A value of 0 disables the timeout.

Ports:
- _clock, in, 1: rising-edge clock.
- _reset, in, 1: asynchronous, active-high reset.
- _start, in, 1: request one reduction. Sampled only in IDLE.
- base / limit / step, in, WIDTH signed: generator arguments. Captured when _start is accepted.
- throttle, in, 1: when high, withholds gen__ready (inserts backpressure).
- _ready, in, 1: caller accepts the result.
- _valid, out, 1: result outputs are valid.
- _busy, out, 1: high in every state except IDLE.
- _count, out, COUNT_WIDTH: number of accepted beats, saturating.
- _sum, out, WIDTH+COUNT_WIDTH signed: sum of sign-extended beats.
- _min / _max, out, WIDTH signed: extremes of the beats.
- _timeout, out, 1: the result was produced by a timeout abort.
- gen_base / gen_limit / gen_step, out, WIDTH signed: registered arguments to the generator.
- gen__start, out, 1: generator start, a one-cycle pulse.
- gen__ready, out, 1: generator ready.
- gen_out0, in, WIDTH signed: generator output beat.
- gen__valid, in, 1: generator output valid.
- gen__done, in, 1: generator finished.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - _valid, _busy, gen__start, gen__ready, _timeout, _count, _sum, _min, _max and gen_* arguments all go to 0.
  - Everything is cleared immediately, with no clock edge required.
- IDLE:
  - On _start: gen_base/limit/step <= base/limit/step.
  - Clear the accumulators, timer and _timeout, then go to START.
- START, exactly 1 cycle:
  - gen__start=1 and gen__ready=0.
  - gen__done and gen__valid are ignored in this cycle, because they may hold stale values from the previous run.
  - Next state is COLLECT.
- COLLECT:
  - gen__ready = !throttle (combinational from state and throttle). gen__start=0.
- Beat accept, when gen__ready && gen__valid at a posedge:
  - _count+1, saturating at 2^COUNT_WIDTH-1.
  - _sum += sext(gen_out0), modular.
  - The first beat loads both _min and _max. Later beats update them with signed compares.
  - The idle timer clears.
- End of stream:
  - Condition: gen__done=1 && gen__valid=0 at a posedge, in any COLLECT cycle including the first.
  - Next state is RESULT.
  - If done and valid are both high, the valid beat is drained first; done is honoured in a later cycle.
- Timeout (TIMEOUT_CYCLES>0):
  - The timer increments on every COLLECT cycle with no accept.
  - When it reaches TIMEOUT_CYCLES, state goes to RESULT with _timeout=1 and the partial results retained.
  - Throttled cycles also count toward the timeout.
- RESULT:
  - _valid=1 and gen__ready=0.
  - All result outputs stay stable until _ready && _valid. Then _valid goes to 0 and state returns to IDLE.
  - _start is ignored here.
- Empty stream: _count=0, _sum=0, _min=0, _max=0.
- Latency:
  - gen__start asserts the cycle after _start is accepted.
  - _valid asserts the cycle after the end-of-stream condition is sampled.
- Throughput: one beat per cycle while throttle is low.
- Reset during COLLECT: gen__ready drops asynchronously. The generator shares _reset, so it returns to its done state.
- State encoding is 2 bits: IDLE, START, COLLECT, RESULT. Unused encodings return to IDLE.

Test Plan:
1. base=1, limit=11, step=3 against a behavioral generator model, _ready=1 -> beats 1, 4, 7, 10; _count=4, _sum=22, _min=1, _max=10, _timeout=0.
2. base=0, limit=10, step=2, throttle toggling every other cycle -> _count=5, _sum=20, _min=0, _max=8. Results are identical with throttle held low, and gen__ready never rises while throttle=1.
3. base=5, limit=5, step=1 (empty range) -> _valid with _count=0, _sum=0, _min=0, _max=0, and gen__start was exactly one cycle wide.
4. TIMEOUT_CYCLES=16, model never asserts valid or done -> _valid 16 cycles after entering COLLECT, _timeout=1, _count=0.
5. Scenario 1 with _ready held low for 5 cycles in RESULT, plus _start pulsed during that window -> outputs are stable, the second start is ignored, and the handshake completes with the same values.
6. Assert _reset mid-COLLECT after 2 beats -> _busy, gen__ready and _valid go to 0 before the next edge. A new _start then reruns scenario 2 with correct results.
